// File: rtl/syn_spi_access_ctrl_pkg.sv
// Shared definitions for the SPI-side synaptic memory access sequencer.
package syn_spi_access_ctrl_pkg;

    localparam int SYN_ADDR_W = 13;   // synaptic memory word address width
    localparam int SYN_WORD_W = 32;   // synaptic memory word width
    localparam int BSEL_LSB   = 13;   // byte-select field inside SPI_ADDR
    localparam int BSEL_MSB   = 14;
    localparam int BSEL_W     = BSEL_MSB - BSEL_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_WR   = 3'd3,
        ST_CAPT = 3'd4,
        ST_ACK  = 3'd5
    } state_t;

endpackage

// File: rtl/syn_spi_access_ctrl.sv
// Initiator-side sequencer: turns SPI synapse read/write commands into
// synaptic memory cycles (read-modify-write for writes, single read for reads).
//
// Handshake: SPI_REQ is a level held by the SPI slave until SPI_ACK pulses for
// one cycle; SPI_ERR and SPI_RDATA are valid in that cycle. A request is taken
// only in IDLE with the activity gate open, and only after SPI_REQ has been
// low at least once since the previous acceptance, so a held request runs once.
module syn_spi_access_ctrl
    import syn_spi_access_ctrl_pkg::*;
#(
    parameter int M      = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  CLK,
    input  logic                  RSTN_syncn,
    input  logic                  SPI_GATE_ACTIVITY_sync,
    input  logic                  SPI_REQ,
    input  logic                  SPI_RNW,
    input  logic [2*M-1:0]        SPI_ADDR,
    input  logic [2*M-1:0]        SPI_WDATA,
    input  logic [SYN_WORD_W-1:0] SYNARRAY_RDATA,
    output logic                  CTRL_SYNARRAY_CS,
    output logic                  CTRL_SYNARRAY_WE,
    output logic [SYN_ADDR_W-1:0] CTRL_SYNARRAY_ADDR,
    output logic [2*M-1:0]        CTRL_PROG_DATA,
    output logic [2*M-1:0]        CTRL_SPI_ADDR,
    output logic                  SPI_ACK,
    output logic                  SPI_ERR,
    output logic [M-1:0]          SPI_RDATA,
    output state_t                dbg_state
);

    // Wait counter only needs to reach RD_LAT-1.
    localparam int              CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CW-1:0]   LAST_CNT = CW'((RD_LAT > 0) ? RD_LAT - 1 : 0);

    state_t              state_q, state_d;
    logic [2*M-1:0]      spi_addr_q;
    logic [2*M-1:0]      prog_data_q;
    logic                rnw_q;
    logic                err_q;
    logic                armed_q;
    logic [CW-1:0]       wait_cnt_q;
    logic [M-1:0]        rdata_q;
    logic [BSEL_W-1:0]   bsel;
    logic                accept;
    logic                gate_drop;

    assign bsel      = spi_addr_q[BSEL_MSB:BSEL_LSB];
    assign accept    = (state_q == ST_IDLE) && SPI_REQ && SPI_GATE_ACTIVITY_sync && armed_q;
    assign gate_drop = ((state_q == ST_RD) || (state_q == ST_WAIT)) && !SPI_GATE_ACTIVITY_sync;

    // State register.
    always_ff @(posedge CLK or negedge RSTN_syncn) begin
        if (!RSTN_syncn) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    // Next-state logic; a closed gate before the write cycle aborts to ACK.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RD;
            ST_RD: begin
                if (!SPI_GATE_ACTIVITY_sync) state_d = ST_ACK;
                else if (RD_LAT > 0)         state_d = ST_WAIT;
                else                         state_d = rnw_q ? ST_CAPT : ST_WR;
            end
            ST_WAIT: begin
                if (!SPI_GATE_ACTIVITY_sync)    state_d = ST_ACK;
                else if (wait_cnt_q == LAST_CNT) state_d = rnw_q ? ST_CAPT : ST_WR;
            end
            ST_WR:   state_d = ST_ACK;
            ST_CAPT: state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode; memory strobes come straight from the state.
    always_comb begin
        CTRL_SYNARRAY_CS = (state_q == ST_RD) || (state_q == ST_WR);
        CTRL_SYNARRAY_WE = (state_q == ST_WR);
        SPI_ACK          = (state_q == ST_ACK);
        SPI_ERR          = (state_q == ST_ACK) && err_q;
    end

    // Command latches, abort flag, re-arm flag, wait counter and read capture.
    always_ff @(posedge CLK or negedge RSTN_syncn) begin
        if (!RSTN_syncn) begin
            spi_addr_q  <= '0;
            prog_data_q <= '0;
            rnw_q       <= 1'b0;
            err_q       <= 1'b0;
            armed_q     <= 1'b1;
            wait_cnt_q  <= '0;
            rdata_q     <= '0;
        end else begin
            if (!SPI_REQ)    armed_q <= 1'b1;
            else if (accept) armed_q <= 1'b0;

            if (accept) begin
                spi_addr_q  <= SPI_ADDR;
                prog_data_q <= SPI_WDATA;
                rnw_q       <= SPI_RNW;
                err_q       <= 1'b0;
            end else if (gate_drop) begin
                err_q <= 1'b1;
            end

            if (state_q == ST_WAIT) wait_cnt_q <= wait_cnt_q + 1'b1;
            else                    wait_cnt_q <= '0;

            if (state_q == ST_CAPT)
                rdata_q <= M'(SYNARRAY_RDATA >> (int'(bsel) * M));
        end
    end

    assign CTRL_SYNARRAY_ADDR = spi_addr_q[SYN_ADDR_W-1:0];
    assign CTRL_SPI_ADDR      = spi_addr_q;
    assign CTRL_PROG_DATA     = prog_data_q;
    assign SPI_RDATA          = rdata_q;
    assign dbg_state          = state_q;

endmodule

// File: tb/tb_syn_spi_access_ctrl.sv
// Self-checking bench for syn_spi_access_ctrl with a synaptic memory stub.
module tb_syn_spi_access_ctrl;
    import syn_spi_access_ctrl_pkg::*;

    localparam int M = 8;

    // ---------------- clock / reset ----------------
    logic        CLK = 1'b0;
    logic        RSTN_syncn = 1'b0;
    logic        gate = 1'b0;
    logic        SPI_REQ = 1'b0;
    logic        SPI_RNW = 1'b0;
    logic [15:0] SPI_ADDR = '0;
    logic [15:0] SPI_WDATA = '0;
    logic [31:0] SYNARRAY_RDATA;
    logic        CTRL_SYNARRAY_CS;
    logic        CTRL_SYNARRAY_WE;
    logic [12:0] CTRL_SYNARRAY_ADDR;
    logic [15:0] CTRL_PROG_DATA;
    logic [15:0] CTRL_SPI_ADDR;
    logic        SPI_ACK;
    logic        SPI_ERR;
    logic [7:0]  SPI_RDATA;
    state_t      dbg_state;

    always #5 CLK = ~CLK;

    syn_spi_access_ctrl #(.M(M), .RD_LAT(1)) dut (
        .CLK                    (CLK),
        .RSTN_syncn             (RSTN_syncn),
        .SPI_GATE_ACTIVITY_sync (gate),
        .SPI_REQ                (SPI_REQ),
        .SPI_RNW                (SPI_RNW),
        .SPI_ADDR               (SPI_ADDR),
        .SPI_WDATA              (SPI_WDATA),
        .SYNARRAY_RDATA         (SYNARRAY_RDATA),
        .CTRL_SYNARRAY_CS       (CTRL_SYNARRAY_CS),
        .CTRL_SYNARRAY_WE       (CTRL_SYNARRAY_WE),
        .CTRL_SYNARRAY_ADDR     (CTRL_SYNARRAY_ADDR),
        .CTRL_PROG_DATA         (CTRL_PROG_DATA),
        .CTRL_SPI_ADDR          (CTRL_SPI_ADDR),
        .SPI_ACK                (SPI_ACK),
        .SPI_ERR                (SPI_ERR),
        .SPI_RDATA              (SPI_RDATA),
        .dbg_state              (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int          errors = 0;
    int          checks = 0;
    logic [8:0]  exp_q[$];       // {err, rdata} per expected ack
    int          we_cnt = 0;
    int          cs_cnt = 0;
    int          ack_cnt = 0;
    logic [31:0] mem [0:8191];   // stub contents (driven by DUT strobes)
    logic [31:0] ref_mem [0:8191]; // reference model contents
    logic [31:0] mem_q = '0;
    logic [7:0]  last_rdata = '0;

    // Merge rule of the synaptic core: mask bit 1 keeps the old bit.
    function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] b,
                                          input logic [15:0] d);
        logic [31:0] r;
        logic [7:0]  o;
        r = w;
        o = w[b*8 +: 8];
        r[b*8 +: 8] = (d[7:0] & ~d[15:8]) | (o & d[15:8]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- synaptic memory stub (registered Q) ----------------
    always @(posedge CLK) begin
        if (CTRL_SYNARRAY_CS) begin
            if (CTRL_SYNARRAY_WE)
                mem[CTRL_SYNARRAY_ADDR] <= merge(mem[CTRL_SYNARRAY_ADDR],
                                                 CTRL_SPI_ADDR[14:13], CTRL_PROG_DATA);
            else
                mem_q <= mem[CTRL_SYNARRAY_ADDR];
        end
    end
    assign SYNARRAY_RDATA = mem_q;

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLK) begin
        if (RSTN_syncn) begin
            if (CTRL_SYNARRAY_WE) we_cnt++;
            if (CTRL_SYNARRAY_CS) cs_cnt++;
            if (CTRL_SYNARRAY_WE && !CTRL_SYNARRAY_CS) begin
                checks++;
                errors++;
                $display("FAIL we_without_cs: WE=1 CS=0 at %0t", $time);
            end
            if (SPI_ACK) begin
                logic [8:0] e;
                ack_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: got err=%0b rdata=0x%0h, expected no ack",
                             SPI_ERR, SPI_RDATA);
                end else begin
                    e = exp_q.pop_front();
                    if ({SPI_ERR, SPI_RDATA} !== e) begin
                        errors++;
                        $display("FAIL ack_response: got err=%0b rdata=0x%0h, expected err=%0b rdata=0x%0h",
                                 SPI_ERR, SPI_RDATA, e[8], e[7:0]);
                    end
                end
            end
        end
    end

    // Reference model: apply a command to the shadow memory, return {err, rdata}.
    task automatic model_cmd(input logic rnw, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic err);
        logic [31:0] w;
        if (!err) begin
            w = ref_mem[addr[12:0]];
            if (rnw) last_rdata = 8'(w >> (32'(addr[14:13]) * 8));
            else     ref_mem[addr[12:0]] = merge(w, addr[14:13], wdata);
        end
        exp_q.push_back({err, last_rdata});
    endtask

    // Wait (bounded) for the ack pulse; lat = negedges counted, 0 if none.
    task automatic wait_ack(input int drop_at, output int lat);
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge CLK);
            if (c == drop_at) gate = 1'b0;
            if (SPI_ACK) begin
                lat = c;
                break;
            end
        end
    endtask

    // Driver: one command; drop_at = negedge index to close the gate (0 = never);
    // hold = cycles to keep SPI_REQ high after the ack.
    task automatic run_cmd(input logic rnw, input logic [15:0] addr, input logic [15:0] wdata,
                           input int drop_at, input int hold);
        int   lat, we0, cs0, ack0;
        logic err;
        @(negedge CLK); #1;
        we0 = we_cnt;
        cs0 = cs_cnt;
        err = (drop_at == 1) || (drop_at == 2);
        model_cmd(rnw, addr, wdata, err);
        SPI_RNW = rnw; SPI_ADDR = addr; SPI_WDATA = wdata; SPI_REQ = 1'b1;
        wait_ack(drop_at, lat);
        check("ack_latency", 64'(lat), err ? 64'(drop_at + 1) : 64'd4);
        #1;
        ack0 = ack_cnt;
        if (hold > 0) begin
            repeat (hold) @(negedge CLK);
            #1;
            check("held_req_single_ack", 64'(ack_cnt - ack0), 64'd0);
        end
        SPI_REQ = 1'b0;
        gate = 1'b1;
        check("we_pulses", 64'(we_cnt - we0), (!err && !rnw) ? 64'd1 : 64'd0);
        check("cs_cycles", 64'(cs_cnt - cs0), (err || rnw) ? 64'd1 : 64'd2);
    endtask

    function automatic logic [56:0] all_outs();
        return {CTRL_SYNARRAY_CS, CTRL_SYNARRAY_WE, CTRL_SYNARRAY_ADDR, CTRL_PROG_DATA,
                CTRL_SPI_ADDR, SPI_ACK, SPI_ERR, SPI_RDATA};
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int          lat, cs0, ack0, found, bad;
        logic [15:0] a, d;
        logic [12:0] words[4];

        for (int i = 0; i < 8192; i++) mem[i] = $urandom;
        mem[5] = 32'hAABB_CCDD;
        for (int i = 0; i < 8192; i++) ref_mem[i] = mem[i];

        // Reset state
        repeat (3) @(negedge CLK);
        check("reset_outputs", 64'(all_outs()), 64'd0);
        RSTN_syncn = 1'b1;
        gate = 1'b1;
        @(negedge CLK);
        check("idle_after_reset", 64'(dbg_state), 64'(ST_IDLE));

        // Directed write: byte 2 of word 5, keep low nibble
        run_cmd(1'b0, 16'h4005, 16'h0F35, 0, 0);
        check("rmw_word5", 64'(mem[5]), 64'h0000_0000_AA3B_CCDD);

        // Directed read: byte 3 of word 5
        run_cmd(1'b1, 16'h6005, 16'h0000, 0, 0);
        check("read_byte3", 64'(SPI_RDATA), 64'hAA);

        // Gate closed at request: command waits, then runs after gate rises
        @(negedge CLK); #1;
        cs0 = cs_cnt; ack0 = ack_cnt;
        gate = 1'b0;
        model_cmd(1'b0, 16'h2010, 16'h00C3, 1'b0);
        SPI_RNW = 1'b0; SPI_ADDR = 16'h2010; SPI_WDATA = 16'h00C3; SPI_REQ = 1'b1;
        repeat (10) @(negedge CLK);
        #1;
        check("gated_no_cs", 64'(cs_cnt - cs0), 64'd0);
        check("gated_no_ack", 64'(ack_cnt - ack0), 64'd0);
        gate = 1'b1;
        wait_ack(0, lat);
        check("gate_rise_latency", 64'(lat), 64'd4);
        SPI_REQ = 1'b0;

        // Gate falls during WAIT of a write, and during RD of a read
        run_cmd(1'b0, 16'h2009, 16'h00FF, 2, 0);
        run_cmd(1'b1, 16'h0009, 16'h0000, 1, 0);

        // Held request: one ack only; the next command needs REQ low first
        run_cmd(1'b0, 16'h0003, 16'h5A00, 0, 20);
        run_cmd(1'b1, 16'h0003, 16'h0000, 0, 0);

        // Asynchronous reset in the middle of the write cycle
        @(negedge CLK); #1;
        SPI_RNW = 1'b0; SPI_ADDR = 16'h2007; SPI_WDATA = 16'h0011; SPI_REQ = 1'b1;
        found = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (CTRL_SYNARRAY_WE) begin
                found = 1;
                break;
            end
        end
        check("reached_wr", 64'(found), 64'd1);
        #2 RSTN_syncn = 1'b0;
        #1 check("async_reset_outputs", 64'(all_outs()), 64'd0);
        SPI_REQ = 1'b0;
        last_rdata = '0;
        repeat (2) @(negedge CLK);
        RSTN_syncn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            check("post_reset_no_ack", 64'(SPI_ACK), 64'd0);
            check("post_reset_idle", 64'(dbg_state), 64'(ST_IDLE));
        end

        // Randomized commands over a few hot words including the top address
        words[0] = 13'd5; words[1] = 13'd0; words[2] = 13'h1FFF; words[3] = 13'($urandom);
        for (int n = 0; n < 60; n++) begin
            a = {1'($urandom), 2'($urandom), words[$urandom_range(0, 3)]};
            d = 16'($urandom);
            run_cmd(1'($urandom), a, d, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0, 0);
        end

        // Final scoreboard drain and memory comparison
        repeat (5) @(negedge CLK);
        check("exp_queue_empty", 64'(exp_q.size()), 64'd0);
        bad = 0;
        for (int i = 0; i < 8192; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("memory_words_mismatched", 64'(bad), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/syn_spi_access_ctrl.md
Name: syn_spi_access_ctrl

Overview:
Initiator-side sequencer that turns SPI-side synapse read and write commands into synaptic memory access cycles for synaptic_core.
- Writes: a read-modify-write pair of memory cycles; synaptic_core performs the masked byte merge in the write cycle.
- Reads: one memory read, then returns the addressed byte.
- Sits between the SPI register slave and synaptic_core's CTRL_SYNARRAY_*, CTRL_PROG_DATA and CTRL_SPI_ADDR inputs.
- Operates only while activity is gated (SPI_GATE_ACTIVITY_sync=1).

Parameters:
M, 8, byte width; data/mask bus is 2*M.
RD_LAT, 1, synaptic memory read latency in cycles (0 = combinational spo, 1 = registered Q).

Ports:
CLK  input  1  clock
RSTN_syncn  input  1  reset, asynchronous, active-low
SPI_GATE_ACTIVITY_sync  input  1  SPI access window; accesses allowed only when 1
SPI_REQ  input  1  command request, level; held until SPI_ACK
SPI_RNW  input  1  1 = read, 0 = write
SPI_ADDR  input  2*M  [12:0] word address, [14:13] byte select, [15] ignored
SPI_WDATA  input  2*M  [M-1:0] data, [2M-1:M] keep-mask (1 = keep old bit)
SYNARRAY_RDATA  input  32  memory read data from synaptic_core
CTRL_SYNARRAY_CS  output  1  memory chip select
CTRL_SYNARRAY_WE  output  1  memory write enable
CTRL_SYNARRAY_ADDR  output  13  memory word address
CTRL_PROG_DATA  output  2*M  latched SPI_WDATA
CTRL_SPI_ADDR  output  2*M  latched SPI_ADDR
SPI_ACK  output  1  one-cycle completion pulse
SPI_ERR  output  1  valid with SPI_ACK; 1 = aborted
SPI_RDATA  output  M  read byte; valid from SPI_ACK until the next accepted command

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; all outputs 0; latches 0.
- FSM states: IDLE, RD, WAIT, WR, CAPT, ACK.
- IDLE:
  - SPI_REQ=1 and SPI_GATE_ACTIVITY_sync=1: latch SPI_ADDR into CTRL_SPI_ADDR, SPI_WDATA into CTRL_PROG_DATA, SPI_RNW internally; go to RD.
  - SPI_REQ=1 with gate=0: command stays pending; no ack.
- RD (1 cycle): CS=1, WE=0, ADDR=latched[12:0]. Next state is WAIT if RD_LAT>0, otherwise WR (write) or CAPT (read).
- WAIT: CS=0; a cycle counter runs RD_LAT-1 extra cycles, so RD_LAT=1 spends exactly 1 cycle here. Then go to WR or CAPT.
- WR (1 cycle): CS=1, WE=1, same address. The ADDR/PROG_DATA/SPI_ADDR outputs are unchanged, so synaptic_core writes the merged word: byte b = CTRL_SPI_ADDR[14:13] becomes (data & ~mask) | (old & mask); other bytes are rewritten unchanged. Go to ACK.
- CAPT (1 cycle): SPI_RDATA <= SYNARRAY_RDATA[8b+7:8b]; CS=0. Go to ACK.
- ACK (1 cycle): SPI_ACK=1, SPI_ERR as flagged. Go to IDLE. A new command is accepted in IDLE only after SPI_REQ has been seen low for at least one cycle (edge re-arm), so one held request cannot be executed twice.
- Latency from accept to ACK with RD_LAT=1: write 4 cycles (RD, WAIT, WR, ACK); read 4 cycles (RD, WAIT, CAPT, ACK). With RD_LAT=0 both are 3 cycles.
- Gate drop: if SPI_GATE_ACTIVITY_sync falls in RD or WAIT, skip WR/CAPT, go to ACK with SPI_ERR=1, and perform no write. WR itself is never interrupted.
- SPI_REQ dropping mid-operation: ignored; the operation completes and acks.
- CS and WE are never both high outside WR. WE is never high without CS.
- Address [12:0] covers the full 8192-word range with no wrap logic. SPI_ADDR[15] is stored in CTRL_SPI_ADDR but has no effect.

Decomposition:
- Shared package: FSM state encoding, SYN_ADDR_W=13, SYN_WORD_W=32, byte-select field positions [14:13].
- No sub-module. The byte-select read mux is inline.

Test Plan:
- Write: gate=1, word 0x0005 preloaded 0xAABBCCDD, ADDR=0x4005 (byte 2), WDATA=0x0F_35 -> CS/WE pattern RD(WE=0), WAIT, WR(WE=1) at address 0x0005; ACK 4 cycles after accept; word becomes 0xAA3BCCDD; ERR=0.
- Read: ADDR=0x6005 -> SPI_RDATA=0xAA, ACK with ERR=0, no WE pulse.
- Gate low at request -> no CS activity, no ACK; raise gate 10 cycles later -> command executes, ACK 4 cycles after gate rise.
- Gate falls during WAIT of a write -> ACK with ERR=1, memory unchanged, WE never asserted.
- SPI_REQ held high for 20 cycles -> exactly one ACK; a second command runs only after REQ low then high.
- Reset asserted asynchronously mid-WR -> all outputs 0 immediately; after release, state IDLE with SPI_ACK=0.
